reg_bank_arbiter: RTL
=====================

Name: reg_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared bank of posedge D flip-flop registers.
- Four requesters share one bank of 2^ADDR_W registers, each WIDTH bits wide.
- Only the granted requester may write a register or read one back.
- Grants are bounded by MAX_HOLD so no requester can starve the others.

Parameters:
WIDTH, 8, data width of each bank register
ADDR_W, 2, address width; the bank holds 2^ADDR_W registers
MAX_HOLD, 4, maximum accesses per grant before forced re-arbitration (must be >= 1)

Ports:
clock  input  1  single system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req  input  4  per-requester request; bit i belongs to requester i
wr  input  4  per-requester access type: 1 = write, 0 = read
addr  input  4*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W]
wdata  input  4*WIDTH  requester i write data in bits [i*WIDTH +: WIDTH]
gnt  output  4  one-hot grant (or all zero), registered
busy  output  1  equals |gnt
rdata  output  WIDTH  registered read data
rvalid  output  1  one-cycle pulse marking new rdata

Behaviour:
- Reset (synchronous, highest priority):
  - gnt=0, rvalid=0, rdata=0, all bank registers=0.
  - Round-robin pointer ptr=0, hold_cnt=0, state IDLE.
  - Any access sampled in a reset cycle is discarded.
- State IDLE:
  - At each edge with |req, select the first requester with req set, scanning ptr, ptr+1, ... modulo 4.
  - gnt becomes one-hot for that owner after that edge; hold_cnt=0; go to OWNED.
  - Grant latency is therefore 1 cycle from req sampled high to gnt high.
- State OWNED (owner o):
  - Each cycle with req[o]=1 is an access; at the edge, hold_cnt increments.
  - Write (wr[o]=1): bank[addr_o] <= wdata_o.
  - Read (wr[o]=0): rdata <= bank[addr_o] and rvalid=1 for exactly the next cycle.
  - Read latency is 1 cycle. rdata holds its value until the next read.
- Release conditions (evaluated at the edge):
  - (a) req[o]=0: no access occurs that cycle.
  - (b) The access taken at this edge brings hold_cnt to MAX_HOLD.
- On release:
  - ptr = o+1 mod 4.
  - Re-arbitrate at the same edge over the current req, starting from ptr.
  - In case (a), requester o is excluded from this re-arbitration.
  - In case (b), requester o is included, so a sole requester is re-granted with no gap.
  - If a winner exists: gnt switches directly to the winner (no bubble), hold_cnt=0, stay in OWNED.
  - If no winner: gnt=0, go to IDLE.
- At most one bank access per cycle, so there are no write/read conflicts.
- Bank contents are visible only through reads.
- Inputs from non-granted requesters are ignored.
- gnt is never multi-hot.
- hold_cnt width is clog2(MAX_HOLD+1) bits and saturates by design, never wrapping.

Test Plan:
1. Reset with req=4'b1111 -> gnt=0, rvalid=0 during reset. First grant after reset deasserts is gnt=4'b0001 (ptr=0).
2. req0 held; cycle 1 wr=1, addr=2, wdata=8'hA5; cycle 2 wr=0, addr=2 -> gnt=0001 one cycle after req0. Read returns rdata=8'hA5 with a one-cycle rvalid pulse. Other registers read 8'h00.
3. req=4'b1111 held, MAX_HOLD=4 -> gnt sequence 0001x4, 0010x4, 0100x4, 1000x4, 0001 with no idle cycles. Exactly 4 accesses per grant.
4. Owner 1 drops req after 2 accesses while req2=1 and req3=1 -> gnt=0100 the next cycle with no bubble. ptr advances past 1. Requester 1 made no access in the drop cycle.
5. Only req3=1 for 10 cycles -> gnt stays 1000 continuously across the MAX_HOLD boundary. 10 accesses complete.
6. Reset asserted in the same cycle as a granted write of 8'h3C to reg 1 -> register 1 stays 8'h00 and gnt=0 on the next cycle.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter for four requesters sharing a bank of 2^ADDR_W registers.
// The granted requester reads or writes one register per cycle, for at most MAX_HOLD accesses per grant.
module reg_bank_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [3:0]            wr,
  input  logic [4*ADDR_W-1:0]   addr,
  input  logic [4*WIDTH-1:0]    wdata,
  output logic [3:0]            gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid
);

  localparam int unsigned NREQ   = 4;
  localparam int unsigned NREG   = 1 << ADDR_W;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_owner, w_owner_nxt;
  logic [1:0]          r_ptr, w_ptr_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt, w_hold_inc;
  logic [3:0]          r_gnt, w_gnt_nxt;
  logic                r_busy;
  logic [WIDTH-1:0]    r_rdata;
  logic                r_rvalid;
  logic [WIDTH-1:0]    r_bank [NREG];

  logic [ADDR_W-1:0]   w_addr_a  [NREQ];
  logic [WIDTH-1:0]    w_wdata_a [NREQ];
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [WIDTH-1:0]    w_acc_wdata;
  logic                w_acc, w_acc_wr, w_rel_a, w_rel_b;
  logic [3:0]          w_mask;
  logic [2:0]          w_pick;

  // First set bit of i_mask scanning from i_start upward (mod 4); bit 2 of the result flags a hit.
  function automatic logic [2:0] f_pick(input logic [3:0] i_mask, input logic [1:0] i_start);
    logic [2:0] v_res;
    logic [1:0] v_idx;
    v_res = '0;
    for (int k = 3; k >= 0; k--) begin
      v_idx = i_start + 2'(k);
      if (i_mask[v_idx]) v_res = {1'b1, v_idx};
    end
    return v_res;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
      w_wdata_a[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  assign w_acc_addr  = w_addr_a[r_owner];
  assign w_acc_wdata = w_wdata_a[r_owner];
  assign w_acc_wr    = wr[r_owner];
  assign w_hold_inc  = r_hold + HOLD_W'(1);

  // Next-state: grant from IDLE, count accesses while OWNED, re-arbitrate on release.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_gnt_nxt   = r_gnt;
    w_mask      = '0;
    w_pick      = '0;
    w_acc       = 1'b0;
    w_rel_a     = 1'b0;
    w_rel_b     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pick = f_pick(req, r_ptr);
        if (w_pick[2]) begin
          w_state_nxt = ST_OWNED;
          w_owner_nxt = w_pick[1:0];
          w_hold_nxt  = '0;
          w_gnt_nxt   = 4'(1) << w_pick[1:0];
        end else begin
          w_gnt_nxt   = '0;
        end
      end
      ST_OWNED: begin
        w_acc   = req[r_owner];
        w_rel_a = !req[r_owner];
        w_rel_b = w_acc && (w_hold_inc == HOLD_W'(MAX_HOLD));
        if (w_acc) w_hold_nxt = w_hold_inc;
        if (w_rel_a || w_rel_b) begin
          w_ptr_nxt = r_owner + 2'd1;
          // A dropping owner may not win; an exhausted owner may be re-granted without a gap.
          w_mask    = w_rel_a ? (req & ~(4'(1) << r_owner)) : req;
          w_pick    = f_pick(w_mask, w_ptr_nxt);
          w_hold_nxt = '0;
          if (w_pick[2]) begin
            w_owner_nxt = w_pick[1:0];
            w_gnt_nxt   = 4'(1) << w_pick[1:0];
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_bank   <= '{default: '0};
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_hold   <= w_hold_nxt;
      r_gnt    <= w_gnt_nxt;
      r_busy   <= |w_gnt_nxt;
      r_rvalid <= w_acc && !w_acc_wr;
      if (w_acc && w_acc_wr)  r_bank[w_acc_addr] <= w_acc_wdata;
      if (w_acc && !w_acc_wr) r_rdata <= r_bank[w_acc_addr];
    end
  end

  assign gnt    = r_gnt;
  assign busy   = r_busy;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;

endmodule
